// File: rtl/clause_sched_pkg.sv
// Shared types, default sizes and the masked-field helper for the clause update scheduler.
package clause_sched_pkg;

    localparam int unsigned DEF_NUM_CLAUSES = 16;
    localparam int unsigned DEF_VARS_PER_CLAUSE = 3;
    localparam int unsigned DEF_NUM_REQ = 3;

    // Widest clause field the helper below can merge; callers zero-extend and truncate.
    localparam int unsigned FIELD_W_MAX = 32;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2
    } sched_state_e;

    // Overwrite only the bits selected by mask; untouched bits keep their current value.
    function automatic logic [FIELD_W_MAX-1:0] apply_mask(
        input logic [FIELD_W_MAX-1:0] cur,
        input logic [FIELD_W_MAX-1:0] val,
        input logic [FIELD_W_MAX-1:0] mask
    );
        return (cur & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/clause_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    // Scan ptr, ptr+1, ... modulo NUM_REQ and lock onto the first requester found.
    always_comb begin
        logic [PTR_W-1:0] cand;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o  = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = cand;
            end
        end
    end

endmodule

// File: rtl/clause_update_scheduler.sv
// Sole writer of the clause assignment latch: holds the shadow assignment vector,
// serially loads it, then applies one masked clause update per grant with a settle gap.
module clause_update_scheduler
    import clause_sched_pkg::*;
#(
    parameter int unsigned NUM_CLAUSES         = DEF_NUM_CLAUSES,
    parameter int unsigned NUM_VARS_PER_CLAUSE = DEF_VARS_PER_CLAUSE,
    parameter int unsigned NUM_REQ             = DEF_NUM_REQ,
    parameter int unsigned IDX_W               = $clog2(NUM_CLAUSES)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       load_start,
    input  logic                                       load_valid,
    input  logic [NUM_VARS_PER_CLAUSE-1:0]             load_data,
    output logic                                       load_ready,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]                   req_idx,
    input  logic [NUM_REQ*NUM_VARS_PER_CLAUSE-1:0]     req_val,
    input  logic [NUM_REQ*NUM_VARS_PER_CLAUSE-1:0]     req_mask,
    output logic [NUM_REQ-1:0]                         req_ready,
    output logic [NUM_VARS_PER_CLAUSE*NUM_CLAUSES-1:0] next_clauses,
    output logic                                       busy,
    output logic                                       settled,
    output logic                                       err_bad_idx
);

    localparam int unsigned V     = NUM_VARS_PER_CLAUSE;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e     state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lidx_q, lidx_d;
    logic [V-1:0]     shadow_q [NUM_CLAUSES];
    logic             settled_q, settled_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_vld;

    logic               grant_en;
    logic               beat;
    logic               idx_ok;
    logic               upd_en;
    logic [IDX_W-1:0]   g_idx;
    logic [V-1:0]       g_val;
    logic [V-1:0]       g_mask;
    logic [V-1:0]       cur_field;
    logic [V-1:0]       upd_field;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_vld)
    );

    // Handshake qualification: grants only while idle in RUN and not preempted by a load.
    always_comb begin
        grant_en   = (state_q == S_RUN) && !load_start && arb_vld;
        req_ready  = grant_en ? arb_gnt : '0;
        load_ready = (state_q == S_LOAD);
        beat       = load_ready && load_valid;
        busy       = (state_q != S_RUN);
    end

    // Route the winning requester's index, value and mask, and build its merged clause field.
    always_comb begin
        g_idx     = '0;
        g_val     = '0;
        g_mask    = '0;
        cur_field = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (arb_idx == PTR_W'(r)) begin
                g_idx  = req_idx[r*IDX_W +: IDX_W];
                g_val  = req_val[r*V +: V];
                g_mask = req_mask[r*V +: V];
            end
        end
        for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
            if (32'(g_idx) == c) begin
                cur_field = shadow_q[c];
            end
        end
        idx_ok    = (32'(g_idx) < NUM_CLAUSES);
        upd_en    = grant_en && idx_ok;
        upd_field = V'(apply_mask(FIELD_W_MAX'(cur_field), FIELD_W_MAX'(g_val),
                                  FIELD_W_MAX'(g_mask)));
    end

    // Next-state logic for the RUN / LOAD / SETTLE sequencer, rr pointer and load index.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lidx_d    = lidx_q;
        settled_d = !(upd_en || beat);
        err_d     = grant_en && !idx_ok;
        unique case (state_q)
            S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    lidx_d  = '0;
                end else if (arb_vld) begin
                    rr_ptr_d = PTR_W'((32'(arb_idx) + 1) % NUM_REQ);
                    state_d  = S_SETTLE;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    lidx_d = lidx_q + IDX_W'(1);
                    if (32'(lidx_q) == NUM_CLAUSES - 1) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Control registers; reset returns to RUN with an unsettled latch view.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            rr_ptr_q  <= '0;
            lidx_q    <= '0;
            settled_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lidx_q    <= lidx_d;
            settled_q <= settled_d;
            err_q     <= err_d;
        end
    end

    // Shadow assignment vector: cleared on reset, written by a load beat or a valid grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
                if (beat && (32'(lidx_q) == c)) begin
                    shadow_q[c] <= load_data;
                end else if (upd_en && (32'(g_idx) == c)) begin
                    shadow_q[c] <= upd_field;
                end
            end
        end
    end

    // Flatten the shadow into the latch input bus, clause c at [c*V +: V].
    always_comb begin
        next_clauses = '0;
        for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
            next_clauses[c*V +: V] = shadow_q[c];
        end
    end

    assign settled     = settled_q;
    assign err_bad_idx = err_q;

endmodule

// File: tb/tb_clause_update_scheduler.sv
// Randomised bench for clause_update_scheduler with a transaction-level reference model
// and a downstream clause assignment latch.
module tb_clause_update_scheduler;

    localparam int NC = 16;
    localparam int V  = 3;
    localparam int NR = 3;
    localparam int IW = 5;

    localparam int M_RUN    = 0;
    localparam int M_LOAD   = 1;
    localparam int M_SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              load_valid;
    logic [V-1:0]      load_data;
    logic              load_ready;
    logic [NR-1:0]     req_valid;
    logic [NR*IW-1:0]  req_idx;
    logic [NR*V-1:0]   req_val;
    logic [NR*V-1:0]   req_mask;
    logic [NR-1:0]     req_ready;
    logic [V*NC-1:0]   next_clauses;
    logic              busy;
    logic              settled;
    logic              err_bad_idx;
    logic [V*NC-1:0]   latch_q;

    int checks   = 0;
    int failures = 0;

    logic [V-1:0] m_cl [NC];
    int           m_ptr;
    int           m_mode;
    int           m_lidx;
    bit           m_settled;
    bit           m_err;

    always #5 clk = ~clk;

    clause_update_scheduler #(
        .NUM_CLAUSES         (NC),
        .NUM_VARS_PER_CLAUSE (V),
        .NUM_REQ             (NR),
        .IDX_W               (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .req_valid    (req_valid),
        .req_idx      (req_idx),
        .req_val      (req_val),
        .req_mask     (req_mask),
        .req_ready    (req_ready),
        .next_clauses (next_clauses),
        .busy         (busy),
        .settled      (settled),
        .err_bad_idx  (err_bad_idx)
    );

    // Downstream clause assignment latch: captures the scheduler output every edge.
    always_ff @(posedge clk) latch_q <= next_clauses;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) m_cl[c] = '0;
        m_ptr     = 0;
        m_mode    = M_RUN;
        m_lidx    = 0;
        m_settled = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic clear_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        req_valid  = '0;
        req_idx    = '0;
        req_val    = '0;
        req_mask   = '0;
    endtask

    task automatic set_req(input int r, input int idx, input logic [V-1:0] val,
                           input logic [V-1:0] mask);
        req_valid[r]          = 1'b1;
        req_idx[r*IW +: IW]   = IW'(idx);
        req_val[r*V +: V]     = val;
        req_mask[r*V +: V]    = mask;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [NR-1:0]   e_rdy;
        logic [V*NC-1:0] e_bus;
        int              g;
        int              gidx;
        logic [V-1:0]    gval;
        logic [V-1:0]    gmask;
        bit              n_settled;
        bit              n_err;
        #1;
        e_rdy = '0;
        g     = -1;
        if (m_mode == M_RUN && !load_start) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        for (int c = 0; c < NC; c++) e_bus[c*V +: V] = m_cl[c];
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("load_ready", 64'(load_ready), 64'(m_mode == M_LOAD));
            chk("busy", 64'(busy), 64'(m_mode != M_RUN));
            chk("next_clauses", 64'(next_clauses), 64'(e_bus));
            chk("settled", 64'(settled), 64'(m_settled));
            chk("err_bad_idx", 64'(err_bad_idx), 64'(m_err));
            if (m_settled) chk("latch_out", 64'(latch_q), 64'(e_bus));
        end
        gidx  = 0;
        gval  = '0;
        gmask = '0;
        if (g >= 0) begin
            gidx  = int'(req_idx[g*IW +: IW]);
            gval  = req_val[g*V +: V];
            gmask = req_mask[g*V +: V];
        end
        n_settled = 1'b1;
        n_err     = 1'b0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (load_start) begin
                        m_mode = M_LOAD;
                        m_lidx = 0;
                    end else if (g >= 0) begin
                        if (gidx < NC) begin
                            m_cl[gidx] = (m_cl[gidx] & ~gmask) | (gval & gmask);
                            n_settled  = 1'b0;
                        end else begin
                            n_err = 1'b1;
                        end
                        m_ptr  = (g + 1) % NR;
                        m_mode = M_SETTLE;
                    end
                end
                M_LOAD: begin
                    if (load_valid) begin
                        m_cl[m_lidx] = load_data;
                        n_settled    = 1'b0;
                        if (m_lidx == NC - 1) m_mode = M_SETTLE;
                        m_lidx++;
                    end
                end
                default: m_mode = M_RUN;
            endcase
            m_settled = n_settled;
            m_err     = n_err;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst = 1'b1;

        // Reset, then idle.
        cycle();
        cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Continuous serial load of clause k = k mod 8.
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        for (int k = 0; k < NC; k++) begin
            load_valid = 1'b1;
            load_data  = V'(k % 8);
            cycle();
        end
        load_valid = 1'b0;
        repeat (3) cycle();
        chk("load_clause7", 64'(next_clauses[7*V +: V]), 64'(3'd7));
        chk("load_clause12", 64'(next_clauses[12*V +: V]), 64'(3'd4));

        // All three requesters held: round-robin bit0 sets on clauses 2, 5, 9.
        set_req(0, 2, 3'b111, 3'b001);
        set_req(1, 5, 3'b111, 3'b001);
        set_req(2, 9, 3'b111, 3'b001);
        repeat (12) cycle();
        clear_inputs();
        repeat (2) cycle();
        chk("rr_clause2", 64'(next_clauses[2*V +: V]), 64'(3'b011));
        chk("rr_clause5", 64'(next_clauses[5*V +: V]), 64'(3'b101));
        chk("rr_clause9", 64'(next_clauses[9*V +: V]), 64'(3'b001));

        // Clause 4 forced to 101, then partial-mask update from r1.
        set_req(1, 4, 3'b101, 3'b111);
        cycle();
        clear_inputs();
        cycle();
        set_req(1, 4, 3'b010, 3'b110);
        cycle();
        clear_inputs();
        repeat (3) cycle();
        chk("mask_clause4", 64'(next_clauses[4*V +: V]), 64'(3'b011));

        // Out-of-range index from r2.
        set_req(2, 20, 3'b111, 3'b111);
        cycle();
        clear_inputs();
        repeat (3) cycle();

        // load_start beats a request; reset lands mid-load.
        load_start = 1'b1;
        set_req(0, 3, 3'b111, 3'b111);
        cycle();
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = V'($urandom);
            cycle();
        end
        rst        = 1'b1;
        load_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("midload_rst_shadow", 64'(next_clauses), 64'(0));
        chk("midload_rst_busy", 64'(busy), 64'(0));
        cycle();

        // Randomised traffic with occasional loads, stalls and resets.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 249) == 0);
            load_start = ($urandom_range(0, 39) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = V'($urandom);
            req_valid  = NR'($urandom);
            for (int r = 0; r < NR; r++) begin
                req_idx[r*IW +: IW] = IW'($urandom_range(0, 19));
                req_val[r*V +: V]   = V'($urandom);
                req_mask[r*V +: V]  = V'($urandom);
            end
            cycle();
        end
        clear_inputs();
        rst = 1'b0;
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
